// File: rtl/cpu_mem_bus_master.sv
// CPU-side initiator for the half-rate test memory bus.
// One request at a time; 32-bit accesses go out as two big-endian 16-bit beats.
module cpu_mem_bus_master #(
    parameter int HOLD_CYCLES = 2,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_sz,
    input  logic                  req_we,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [15:0]           mem_write_data_out,
    output logic                  mem_data_acc_sz,
    output logic                  mem_write_data_we,
    input  logic [15:0]           mem_read_data_in
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_8   = 2'd0;
    localparam logic [1:0] SZ_16  = 2'd1;
    localparam logic [1:0] SZ_32  = 2'd2;
    localparam logic [1:0] SZ_BAD = 2'd3;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            hold_q, hold_d;
    logic                  beat_q, beat_d;
    logic                  ready_q;
    logic                  accept;
    logic                  on_bus;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH-1:0] beat_off;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [1:0]            sz_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           cap_word;
    logic [15:0]           wr_word;

    // ready_q only rises while parked in IDLE, so it doubles as the IDLE qualifier
    assign accept    = req_valid & ready_q;
    assign on_bus    = (state_q == BEAT) || (state_q == CAPTURE);
    assign beat_off  = beat_q ? ADDR_WIDTH'(2) : '0;
    assign beat_addr = addr_q + beat_off;

    assign req_ready          = ready_q;
    assign resp_valid         = (state_q == RESP);
    assign resp_rdata         = rdata_q;
    assign resp_err           = err_q;
    assign mem_addr_out       = on_bus ? beat_addr : last_addr_q;
    assign mem_write_data_out = wr_word;
    assign mem_data_acc_sz    = (sz_q != SZ_8);
    assign mem_write_data_we  = (state_q == BEAT) & we_q;

    // Sequencer: beat hold counting and beat splitting
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    beat_d  = 1'b0;
                    hold_d  = '0;
                    state_d = (req_sz == SZ_BAD) ? RESP : BEAT;
                end
            end
            BEAT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = CAPTURE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            CAPTURE: begin
                if (sz_q == SZ_32 && !beat_q) begin
                    beat_d  = 1'b1;
                    state_d = BEAT;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Merge the sampled bus word into the right-justified read result
    always_comb begin
        cap_word = '0;
        unique case (sz_q)
            SZ_8:  cap_word = {24'h0, mem_read_data_in[7:0]};
            SZ_16: cap_word = {16'h0, mem_read_data_in};
            default: begin
                if (beat_q) cap_word = {rbuf_q[31:16], mem_read_data_in};
                else        cap_word = {mem_read_data_in, rbuf_q[15:0]};
            end
        endcase
    end

    // Select the 16-bit write word for the current beat
    always_comb begin
        wr_word = '0;
        unique case (sz_q)
            SZ_8:   wr_word = {8'h0, wdata_q[7:0]};
            SZ_16:  wr_word = wdata_q[15:0];
            SZ_32:  wr_word = beat_q ? wdata_q[15:0] : wdata_q[31:16];
            default: wr_word = '0;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            beat_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // Request latch, read assembly and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            sz_q        <= SZ_8;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                sz_q    <= req_sz;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                rbuf_q  <= '0;
                if (req_sz == SZ_BAD) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (on_bus) begin
                last_addr_q <= beat_addr;
            end
            if (state_q == CAPTURE) begin
                rbuf_q <= cap_word;
                if (state_d == RESP) begin
                    rdata_q <= we_q ? 32'h0 : cap_word;
                    err_q   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bus_master.sv
// Scoreboard bench for cpu_mem_bus_master against a half-rate byte memory.
// Expected responses come from a byte-array reference model of the address space.
module tb_cpu_mem_bus_master;

    localparam int HOLD = 2;
    localparam int AW   = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_sz;
    logic          req_we;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr_out;
    logic [15:0]   mem_write_data_out;
    logic          mem_data_acc_sz;
    logic          mem_write_data_we;
    logic [15:0]   mem_read_data_in;

    cpu_mem_bus_master #(
        .HOLD_CYCLES(HOLD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_sz            (req_sz),
        .req_we            (req_we),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .mem_addr_out      (mem_addr_out),
        .mem_write_data_out(mem_write_data_out),
        .mem_data_acc_sz   (mem_data_acc_sz),
        .mem_write_data_we (mem_write_data_we),
        .mem_read_data_in  (mem_read_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-rate big-endian test memory: services the bus every other edge
    logic [7:0]  bus_mem [0:65535] = '{default: 8'h00};
    logic        phase   = 1'b0;
    logic [15:0] mem_rd  = 16'h0;
    assign mem_read_data_in = mem_rd;

    always @(posedge clk) begin
        phase <= ~phase;
        if (phase) begin
            if (mem_write_data_we) begin
                if (mem_data_acc_sz) begin
                    bus_mem[mem_addr_out]         <= mem_write_data_out[15:8];
                    bus_mem[mem_addr_out + 16'd1] <= mem_write_data_out[7:0];
                end else begin
                    bus_mem[mem_addr_out] <= mem_write_data_out[7:0];
                end
            end
            if (mem_data_acc_sz)
                mem_rd <= {bus_mem[mem_addr_out], bus_mem[mem_addr_out + 16'd1]};
            else
                mem_rd <= {8'h00, bus_mem[mem_addr_out]};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flat byte array, accesses are big-endian byte runs
    logic [7:0] ref_mem [0:65535] = '{default: 8'h00};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            r = (r << 8) | {24'h0, ref_mem[16'(a + i)]};
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever a response is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_write_data_we) we_cnt++;
            if (resp_valid) begin
                check("resp_expected", {31'h0, sb.size() != 0}, 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    check("resp_latency", cyc + 1 - e.acc, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [1:0] sz, input logic we,
                         input logic [31:0] wd, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_sz    = sz;
        req_we    = we;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_sz    = 2'($urandom);
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        if (push) begin
            e.acc = cyc;
            if (sz == 2'd3) begin
                e.rdata = 32'h0;
                e.err   = 1'b1;
                e.lat   = 1;
            end else begin
                e.err   = 1'b0;
                e.rdata = we ? 32'h0 : ref_read(a, sz);
                e.lat   = (sz == 2'd2) ? 2 * HOLD + 3 : HOLD + 2;
                if (we) begin
                    for (int i = 0; i < nbytes(sz); i++)
                        ref_mem[16'(a + i)] = 8'(wd >> (8 * (nbytes(sz) - 1 - i)));
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("resp_timeout", 32'h0, 32'h1);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_sz    = '0;
        req_we    = 1'b0;
        req_wdata = '0;

        #3;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_we", {31'h0, mem_write_data_we}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr_out}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_ready_held", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        issue(16'h0010, 2'd1, 1'b1, 32'h0000_BEEF, 1'b1);
        wait_idle();
        check("mem_10", {24'h0, bus_mem[16'h0010]}, 32'hBE);
        check("mem_11", {24'h0, bus_mem[16'h0011]}, 32'hEF);
        issue(16'h0010, 2'd1, 1'b0, 32'h0, 1'b1);
        issue(16'h0011, 2'd0, 1'b0, 32'h0, 1'b1);
        issue(16'h0011, 2'd0, 1'b1, 32'h0000_005A, 1'b1);
        issue(16'h0010, 2'd1, 1'b0, 32'h0, 1'b1);

        issue(16'hFFFE, 2'd2, 1'b1, 32'h1234_5678, 1'b1);
        wait_idle();
        check("mem_fffe", {bus_mem[16'hFFFE], bus_mem[16'hFFFF],
                           bus_mem[16'h0000], bus_mem[16'h0001]}, 32'h1234_5678);
        issue(16'hFFFE, 2'd2, 1'b0, 32'h0, 1'b1);
        wait_idle();

        w0 = we_cnt;
        issue(16'h0020, 2'd3, 1'b1, 32'hDEAD_BEEF, 1'b1);
        wait_idle();
        check("illegal_no_we", we_cnt, w0);

        issue(16'h4000, 2'd1, 1'b1, 32'h0000_CAFE, 1'b0);
        @(posedge clk);
        #2;
        check("beat_we_high", {31'h0, mem_write_data_we}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_we_async", {31'h0, mem_write_data_we}, 32'h0);
        check("rst_ready_async", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mid_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_mid_rst", {31'h0, req_ready}, 32'h1);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            issue(16'(16'hFFF0 + $urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
